// File: rtl/blob_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : blob_frame_gen
//  Purpose  : Synthetic raster source. Streams H_ACTIVE x V_ACTIVE frames of
//             12-bit colour beats. Every pixel is black except one
//             programmable solid rectangle of colour BLOB_COLOR.
//  Revision : 1.0 - initial release
// ============================================================================
module blob_frame_gen #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          H_BLANK    = 160,
  parameter int          V_BLANK    = 1000,
  parameter logic [11:0] BLOB_COLOR = 12'hF00
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic        iBlobLoad,
  input  logic [10:0] iBlobRow,
  input  logic [10:0] iBlobCol,
  input  logic [9:0]  iBlobW,
  input  logic [9:0]  iBlobH,
  output logic [11:0] oColor,
  output logic        oDVAL,
  output logic        oFrameStart,
  output logic        oFrameDone,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  localparam logic [9:0]  c_COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  c_ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [10:0] c_HB_LAST  = 11'(H_BLANK - 1);
  localparam logic [10:0] c_VB_LAST  = 11'(V_BLANK - 1);

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_col, w_col_nxt;
  logic [9:0]  r_row, w_row_nxt;
  logic [10:0] r_blank, w_blank_nxt;
  logic        w_reload;
  logic        w_done_nxt;

  // Pending geometry is written by iBlobLoad; active geometry is what the
  // frame in flight uses and only changes on the frame-start reload.
  logic [10:0] r_pend_row, r_pend_col, r_act_row, r_act_col;
  logic [9:0]  r_pend_w, r_pend_h, r_act_w, r_act_h;
  logic [10:0] w_pend_row, w_pend_col, w_geo_row, w_geo_col;
  logic [9:0]  w_pend_w, w_pend_h, w_geo_w, w_geo_h;

  logic [11:0] w_col_lo, w_col_hi, w_row_lo, w_row_hi, w_colx, w_rowx;
  logic        w_blob;
  logic        w_dval_nxt;
  logic [11:0] w_color_nxt;
  logic        w_fs_nxt;
  logic        w_busy_nxt;

  // Pending value as seen this cycle, so a load coinciding with the
  // frame-start reload is picked up immediately.
  always_comb begin
    w_pend_row = iBlobLoad ? iBlobRow : r_pend_row;
    w_pend_col = iBlobLoad ? iBlobCol : r_pend_col;
    w_pend_w   = iBlobLoad ? iBlobW   : r_pend_w;
    w_pend_h   = iBlobLoad ? iBlobH   : r_pend_h;
  end

  // Next-state and counter sequencing for the raster walk.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_blank_nxt = r_blank;
    w_reload    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iEnable) begin
          w_state_nxt = ST_ACTIVE;
          w_col_nxt   = 10'd0;
          w_row_nxt   = 10'd0;
          w_reload    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (r_col == c_COL_LAST) begin
          if (r_row == c_ROW_LAST) begin
            w_state_nxt = ST_VBLANK;
            w_blank_nxt = 11'd0;
            w_done_nxt  = 1'b1;
          end else if (H_BLANK == 0) begin
            w_col_nxt = 10'd0;
            w_row_nxt = r_row + 10'd1;
          end else begin
            w_state_nxt = ST_HBLANK;
            w_blank_nxt = 11'd0;
          end
        end else begin
          w_col_nxt = r_col + 10'd1;
        end
      end
      ST_HBLANK: begin
        if (r_blank == c_HB_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_col_nxt   = 10'd0;
          w_row_nxt   = r_row + 10'd1;
        end else begin
          w_blank_nxt = r_blank + 11'd1;
        end
      end
      default: begin
        if (r_blank == c_VB_LAST) begin
          w_col_nxt = 10'd0;
          w_row_nxt = 10'd0;
          if (iEnable) begin
            w_state_nxt = ST_ACTIVE;
            w_reload    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_blank_nxt = r_blank + 11'd1;
        end
      end
    endcase
  end

  // Output decode for the beat about to be registered; bounds in 12 bits
  // so start+size never wraps and off-screen parts simply never match.
  always_comb begin
    w_geo_row   = w_reload ? w_pend_row : r_act_row;
    w_geo_col   = w_reload ? w_pend_col : r_act_col;
    w_geo_w     = w_reload ? w_pend_w   : r_act_w;
    w_geo_h     = w_reload ? w_pend_h   : r_act_h;
    w_col_lo    = {1'b0, w_geo_col};
    w_col_hi    = {1'b0, w_geo_col} + {2'b00, w_geo_w};
    w_row_lo    = {1'b0, w_geo_row};
    w_row_hi    = {1'b0, w_geo_row} + {2'b00, w_geo_h};
    w_colx      = {2'b00, w_col_nxt};
    w_rowx      = {2'b00, w_row_nxt};
    w_blob      = (w_geo_w != 10'd0) && (w_geo_h != 10'd0) &&
                  (w_colx >= w_col_lo) && (w_colx < w_col_hi) &&
                  (w_rowx >= w_row_lo) && (w_rowx < w_row_hi);
    w_dval_nxt  = (w_state_nxt == ST_ACTIVE);
    w_color_nxt = (w_dval_nxt && w_blob) ? BLOB_COLOR : 12'h000;
    w_fs_nxt    = w_dval_nxt && (w_row_nxt == 10'd0) && (w_col_nxt == 10'd0);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_col       <= 10'd0;
      r_row       <= 10'd0;
      r_blank     <= 11'd0;
      oColor      <= 12'h000;
      oDVAL       <= 1'b0;
      oFrameStart <= 1'b0;
      oFrameDone  <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_blank     <= w_blank_nxt;
      oColor      <= w_color_nxt;
      oDVAL       <= w_dval_nxt;
      oFrameStart <= w_fs_nxt;
      oFrameDone  <= w_done_nxt;
      oBusy       <= w_busy_nxt;
    end
  end

  // Geometry registers: pending on load, active on frame-start reload.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_pend_row <= 11'd0;
      r_pend_col <= 11'd0;
      r_pend_w   <= 10'd0;
      r_pend_h   <= 10'd0;
      r_act_row  <= 11'd0;
      r_act_col  <= 11'd0;
      r_act_w    <= 10'd0;
      r_act_h    <= 10'd0;
    end else begin
      r_pend_row <= w_pend_row;
      r_pend_col <= w_pend_col;
      r_pend_w   <= w_pend_w;
      r_pend_h   <= w_pend_h;
      if (w_reload) begin
        r_act_row <= w_pend_row;
        r_act_col <= w_pend_col;
        r_act_w   <= w_pend_w;
        r_act_h   <= w_pend_h;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blob_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blob_frame_gen
//  Purpose  : Directed self-checking bench for blob_frame_gen using a reduced
//             16x12 raster (and a zero-blanking 16x12 instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blob_frame_gen;

  localparam int HA = 16;
  localparam int VA = 12;
  localparam int HB = 4;
  localparam int VB = 5;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [10:0] brow, bcol;
  logic [9:0]  bw, bh;
  logic [11:0] color;
  logic        dval, fs, fd, busy;

  logic        en0;
  logic [11:0] color0;
  logic        dval0, fs0, fd0, busy0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  blob_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
                   .BLOB_COLOR(12'hF00)) dut (
    .iCLK(clk), .iRST(rst), .iEnable(en), .iBlobLoad(load),
    .iBlobRow(brow), .iBlobCol(bcol), .iBlobW(bw), .iBlobH(bh),
    .oColor(color), .oDVAL(dval), .oFrameStart(fs), .oFrameDone(fd), .oBusy(busy)
  );

  blob_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(0), .V_BLANK(1),
                   .BLOB_COLOR(12'hF00)) dut0 (
    .iCLK(clk), .iRST(rst), .iEnable(en0), .iBlobLoad(1'b0),
    .iBlobRow(11'd0), .iBlobCol(11'd0), .iBlobW(10'd0), .iBlobH(10'd0),
    .oColor(color0), .oDVAL(dval0), .oFrameStart(fs0), .oFrameDone(fd0), .oBusy(busy0)
  );

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk one frame starting at the negedge showing its first beat. Expected
  // rectangle (br,bc,bw_e,bh_e) gives the required colour of every beat.
  task automatic run_frame(input string tag, input int exp_blob,
                           input int br, input int bc, input int bw_e, input int bh_e,
                           input int load_at, input int lr, input int lc,
                           input int lw, input int lh,
                           input int dis_at, input int rst_at);
    int beats = 0, blobs = 0, col_err = 0, strb_err = 0, done = 0;
    bit fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (k > 0) @(negedge clk);
      load = 1'b0;
      if (dval) begin
        int r, c;
        bit inb;
        r = beats / HA;
        c = beats % HA;
        inb = (bw_e != 0) && (bh_e != 0) && (c >= bc) && (c < bc + bw_e) &&
              (r >= br) && (r < br + bh_e);
        if (color != (inb ? 12'hF00 : 12'h000)) col_err++;
        if (inb) blobs++;
        if (fs != (beats == 0)) strb_err++;
        if (fd) strb_err++;
        if (beats == load_at) begin
          load = 1'b1;
          brow = 11'(lr); bcol = 11'(lc); bw = 10'(lw); bh = 10'(lh);
        end
        if (beats == dis_at) en = 1'b0;
        if (beats == rst_at) begin
          rst = 1'b1;
          en  = 1'b0;
          fin = 1;
        end
        beats++;
      end else if (fd) begin
        done = 1;
        fin  = 1;
      end else begin
        if (color != 12'h000) col_err++;
        if (fs) strb_err++;
      end
    end
    chk_val({tag, " colour errs"}, col_err, 0);
    chk_val({tag, " strobe errs"}, strb_err, 0);
    if (rst_at >= 0) begin
      @(negedge clk);
      chk_val({tag, " rst colour"}, int'(color), 0);
      chk_val({tag, " rst dval"}, int'(dval), 0);
      chk_val({tag, " rst fs"}, int'(fs), 0);
      chk_val({tag, " rst done"}, int'(fd), 0);
      chk_val({tag, " rst busy"}, int'(busy), 0);
      rst = 1'b0;
    end else begin
      chk_val({tag, " done seen"}, done, 1);
      chk_val({tag, " beats"}, beats, HA * VA);
      chk_val({tag, " blob beats"}, blobs, exp_blob);
    end
  endtask

  // From the oFrameDone negedge through vertical blanking; optionally loads
  // geometry in the last blanking cycle (the reload cycle).
  task automatic gap(input string tag, input bit restart, input bit do_load,
                     input int lr, input int lc, input int lw, input int lh);
    int err = 0;
    for (int k = 1; k <= VB; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k < VB) begin
        if (fd || dval || !busy || color != 12'h000) err++;
        if (do_load && k == VB - 1) begin
          load = 1'b1;
          brow = 11'(lr); bcol = 11'(lc); bw = 10'(lw); bh = 10'(lh);
        end
      end
    end
    chk_val({tag, " blank errs"}, err, 0);
    chk_val({tag, " busy"}, int'(busy), int'(restart));
    chk_val({tag, " frame start"}, int'(fs), int'(restart));
  endtask

  initial begin
    int err;
    rst = 1'b1; en = 1'b0; load = 1'b0; en0 = 1'b0;
    brow = '0; bcol = '0; bw = '0; bh = '0;
    repeat (3) @(negedge clk);
    chk_val("reset colour", int'(color), 0);
    chk_val("reset dval", int'(dval), 0);
    chk_val("reset fs", int'(fs), 0);
    chk_val("reset done", int'(fd), 0);
    chk_val("reset busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk_val("first fs", int'(fs), 1);
    chk_val("first busy", int'(busy), 1);

    // Empty geometry; mid-frame load at row 6 must not affect this frame.
    run_frame("F1", 0, 0, 0, 0, 0, 6 * HA, 3, 5, 4, 2, -1, -1);
    gap("G1", 1, 0, 0, 0, 0, 0);
    run_frame("F2", 8, 3, 5, 4, 2, 50, 10, 14, 50, 50, -1, -1);
    gap("G2", 1, 0, 0, 0, 0, 0);
    // Clipped at bottom-right: rows 10-11 x cols 14-15.
    run_frame("F3", 4, 10, 14, 50, 50, 20, 0, 20, 5, 5, -1, -1);
    gap("G3", 1, 0, 0, 0, 0, 0);
    // Column start beyond the line: empty.
    run_frame("F4", 0, 0, 20, 5, 5, -1, 0, 0, 0, 0, -1, -1);
    gap("G4", 1, 1, 0, 0, 3, 2);
    run_frame("F5", 6, 0, 0, 3, 2, -1, 0, 0, 0, 0, -1, -1);
    gap("G5", 1, 0, 0, 0, 0, 0);
    // Reset at row 7, col 3.
    run_frame("F6", 6, 0, 0, 3, 2, -1, 0, 0, 0, 0, -1, 7 * HA + 3);

    err = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || dval || fd || fs) err++;
    end
    chk_val("post-reset idle errs", err, 0);
    en = 1'b1;
    @(negedge clk);
    chk_val("restart fs", int'(fs), 1);
    // Geometry cleared by reset; enable dropped mid-frame must not truncate.
    run_frame("F7", 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 40, -1);
    gap("G7", 0, 0, 0, 0, 0, 0);
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || dval || fs || fd) err++;
    end
    chk_val("stopped idle errs", err, 0);

    // Zero horizontal blanking, one cycle of vertical blanking.
    en0 = 1'b1;
    @(negedge clk);
    chk_val("nb first fs", int'(fs0), 1);
    en0 = 1'b1;
    err = 0;
    for (int k = 1; k < HA * VA; k++) begin
      @(negedge clk);
      if (!dval0 || fs0 || fd0 || color0 != 12'h000) err++;
    end
    chk_val("nb continuous errs", err, 0);
    @(negedge clk);
    chk_val("nb gap dval", int'(dval0), 0);
    chk_val("nb done", int'(fd0), 1);
    @(negedge clk);
    chk_val("nb second fs", int'(fs0), 1);
    chk_val("nb second dval", int'(dval0), 1);
    en0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
